// File: rtl/biquad_sequencer_pkg.sv
// Shared constants for the biquad MAC datapath and its sequencer: word widths, mux select codes, FSM states.
// BIQUAD_BYPASS_EN adds the BYP state.
package biquad_sequencer_pkg;

    localparam int N = 16;
    localparam int F = 14;

    // coefficient select (controlS)
    localparam logic [2:0] SEL_CERO  = 3'd0;
    localparam logic [2:0] SEL_A1    = 3'd1;
    localparam logic [2:0] SEL_A2    = 3'd2;
    localparam logic [2:0] SEL_B0    = 3'd3;
    localparam logic [2:0] SEL_B1    = 3'd4;
    localparam logic [2:0] SEL_B2    = 3'd5;

    // sample select (controlC), zero is 2'b00
    localparam logic [1:0] SEL_FK1   = 2'd1;
    localparam logic [1:0] SEL_FK2   = 2'd2;
    localparam logic [1:0] SEL_FK    = 2'd3;

    // addend select (controlZ), zero is SEL_CERO
    localparam logic [2:0] SEL_UK    = 3'd1;
    localparam logic [2:0] SEL_YK    = 3'd2;
    localparam logic [2:0] SEL_ACUM1 = 3'd3;
    localparam logic [2:0] SEL_ACUM2 = 3'd4;
    localparam logic [2:0] SEL_ACUM3 = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ST1   = 3'd1,
        ST2   = 3'd2,
        ST3   = 3'd3,
        ST4   = 3'd4,
        ST5   = 3'd5,
        SHIFT = 3'd6
`ifdef BIQUAD_BYPASS_EN
        , BYP = 3'd7
`endif
    } state_t;

endpackage

// File: rtl/biquad_sequencer_step_timer.sv
// Step-hold counter: counts while a step is active, flags the last hold cycle (count == MAC_LAT-1).
// Latency: tc is a combinational decode of the registered count. No backpressure.
// Clearing is synchronous; clr wins over counting.
module biquad_sequencer_step_timer #(
    parameter int MAC_LAT = 1,
    parameter int CNT_W   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    assign tc = (cnt == CNT_W'(MAC_LAT - 1));

endmodule

// File: rtl/biquad_sequencer.sv
// Control FSM for the shared biquad MAC: five direct-form-II steps plus delay-line shift per sample strobe.
// Latency: done in cycle 5*MAC_LAT+1 after start (MAC_LAT+1 in bypass). No backpressure: start while busy is dropped and flagged in overrun.
// BIQUAD_BYPASS_EN adds the bypass input (y_k = U_k, delay line frozen).
module biquad_sequencer
    import biquad_sequencer_pkg::*;
#(
    parameter int MAC_LAT = 1,
    parameter int CNT_W   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ovr_clr,
`ifdef BIQUAD_BYPASS_EN
    input  logic       bypass,
`endif
    output logic [2:0] controlS,
    output logic [1:0] controlC,
    output logic [2:0] controlZ,
    output logic       en_acum1,
    output logic       en_acum2,
    output logic       en_acum3,
    output logic       en_fk,
    output logic       en_yk,
    output logic       en_shift,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    state_t state;
    logic   tc;
    logic   stepping;
`ifdef BIQUAD_BYPASS_EN
    logic   byp_r;
`endif

    assign stepping = (state != IDLE) && (state != SHIFT);

    biquad_sequencer_step_timer #(
        .MAC_LAT (MAC_LAT),
        .CNT_W   (CNT_W)
    ) u_step_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (!stepping || tc),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            overrun <= 1'b0;
`ifdef BIQUAD_BYPASS_EN
            byp_r   <= 1'b0;
`endif
        end else begin
            // a new overrun event beats a simultaneous clear
            if (start && state != IDLE)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;

            case (state)
                IDLE: if (start) begin
`ifdef BIQUAD_BYPASS_EN
                    state <= bypass ? BYP : ST1;
                    byp_r <= bypass;
`else
                    state <= ST1;
`endif
                end
                ST1:   if (tc) state <= ST2;
                ST2:   if (tc) state <= ST3;
                ST3:   if (tc) state <= ST4;
                ST4:   if (tc) state <= ST5;
                ST5:   if (tc) state <= SHIFT;
`ifdef BIQUAD_BYPASS_EN
                BYP:   if (tc) state <= SHIFT;
`endif
                SHIFT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        controlS = SEL_CERO;
        controlC = 2'b00;
        controlZ = SEL_CERO;
        en_acum1 = 1'b0;
        en_acum2 = 1'b0;
        en_acum3 = 1'b0;
        en_fk    = 1'b0;
        en_yk    = 1'b0;
        en_shift = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        case (state)
            ST1: begin
                controlS = SEL_A1; controlC = SEL_FK1; controlZ = SEL_UK;    en_acum1 = tc;
            end
            ST2: begin
                controlS = SEL_A2; controlC = SEL_FK2; controlZ = SEL_ACUM1; en_fk    = tc;
            end
            ST3: begin
                controlS = SEL_B0; controlC = SEL_FK;  controlZ = SEL_CERO;  en_acum2 = tc;
            end
            ST4: begin
                controlS = SEL_B1; controlC = SEL_FK1; controlZ = SEL_ACUM2; en_acum3 = tc;
            end
            ST5: begin
                controlS = SEL_B2; controlC = SEL_FK2; controlZ = SEL_ACUM3; en_yk    = tc;
            end
`ifdef BIQUAD_BYPASS_EN
            BYP: begin
                controlZ = SEL_UK; en_yk = tc;
            end
`endif
            SHIFT: begin
                done = 1'b1;
`ifdef BIQUAD_BYPASS_EN
                en_shift = !byp_r;
`else
                en_shift = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_biquad_sequencer.sv
// Directed bench for biquad_sequencer: MAC_LAT=1 and MAC_LAT=3 instances plus a small behavioural datapath on the MAC_LAT=1 one.
// Define BIQUAD_BYPASS_EN to also exercise the bypass path.
module tb_biquad_sequencer;
    import biquad_sequencer_pkg::N;
    import biquad_sequencer_pkg::F;

    logic clk = 1'b0;
    logic reset, start, ovr_clr, bypass;
    always #5 clk = ~clk;

    logic [2:0] s1, z1, s3, z3;
    logic [1:0] c1, c3;
    logic a1_1, a2_1, a3_1, fk_1, yk_1, sh_1, bz_1, dn_1, ov_1;
    logic a1_3, a2_3, a3_3, fk_3, yk_3, sh_3, bz_3, dn_3, ov_3;

    biquad_sequencer #(.MAC_LAT(1), .CNT_W(3)) u1 (
        .clk(clk), .reset(reset), .start(start), .ovr_clr(ovr_clr),
`ifdef BIQUAD_BYPASS_EN
        .bypass(bypass),
`endif
        .controlS(s1), .controlC(c1), .controlZ(z1),
        .en_acum1(a1_1), .en_acum2(a2_1), .en_acum3(a3_1), .en_fk(fk_1), .en_yk(yk_1),
        .en_shift(sh_1), .busy(bz_1), .done(dn_1), .overrun(ov_1));

    biquad_sequencer #(.MAC_LAT(3), .CNT_W(2)) u3 (
        .clk(clk), .reset(reset), .start(start), .ovr_clr(ovr_clr),
`ifdef BIQUAD_BYPASS_EN
        .bypass(bypass),
`endif
        .controlS(s3), .controlC(c3), .controlZ(z3),
        .en_acum1(a1_3), .en_acum2(a2_3), .en_acum3(a3_3), .en_fk(fk_3), .en_yk(yk_3),
        .en_shift(sh_3), .busy(bz_3), .done(dn_3), .overrun(ov_3));

    // {S, C, Z, en_acum1, en_fk, en_acum2, en_acum3, en_yk, en_shift, busy, done, overrun}
    logic [16:0] obs1, obs3;
    assign obs1 = {s1, c1, z1, a1_1, fk_1, a2_1, a3_1, yk_1, sh_1, bz_1, dn_1, ov_1};
    assign obs3 = {s3, c3, z3, a1_3, fk_3, a2_3, a3_3, yk_3, sh_3, bz_3, dn_3, ov_3};

    // behavioural datapath on u1's selects
    logic signed [N-1:0] uk, acum1, acum2, acum3, fk, yk, fk1, fk2, coef, smp, add;
    logic signed [2*N-1:0] prod;
    logic signed [N-1:0] sum;
    always_comb begin
        coef = '0; smp = '0; add = '0;
        case (s1)
            3'd1: coef = -16'sd3000;
            3'd2: coef = 16'sd2000;
            3'd3: coef = 16'sd16351;
            3'd4: coef = 16'sd5000;
            3'd5: coef = -16'sd7000;
            default: coef = '0;
        endcase
        case (c1)
            2'd1: smp = fk1;
            2'd2: smp = fk2;
            2'd3: smp = fk;
            default: smp = '0;
        endcase
        case (z1)
            3'd1: add = uk;
            3'd2: add = yk;
            3'd3: add = acum1;
            3'd4: add = acum2;
            3'd5: add = acum3;
            default: add = '0;
        endcase
        prod = coef * smp;
        sum  = N'(prod >>> F) + add;
    end
    always @(posedge clk) begin
        if (reset) begin
            acum1 <= '0; acum2 <= '0; acum3 <= '0; fk <= '0; yk <= '0; fk1 <= '0; fk2 <= '0;
        end else begin
            if (a1_1) acum1 <= sum;
            if (fk_1) fk    <= sum;
            if (a2_1) acum2 <= sum;
            if (a3_1) acum3 <= sum;
            if (yk_1) yk    <= sum;
            if (sh_1) begin fk2 <= fk1; fk1 <= fk; end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] mk(input logic [2:0] s, input logic [1:0] c, input logic [2:0] z,
                                       input logic [4:0] en, input logic sh, input logic bz,
                                       input logic dn, input logic ov);
        return {s, c, z, en, sh, bz, dn, ov};
    endfunction

    // k: 0 idle, 1..5 step, 6 shift; en = load enable of that step
    function automatic logic [16:0] expv(input int k, input logic en, input logic ov);
        case (k)
            1: return mk(3'd1, 2'd1, 3'd1, {en, 4'b0000}, 1'b0, 1'b1, 1'b0, ov);
            2: return mk(3'd2, 2'd2, 3'd3, {1'b0, en, 3'b000}, 1'b0, 1'b1, 1'b0, ov);
            3: return mk(3'd3, 2'd3, 3'd0, {2'b00, en, 2'b00}, 1'b0, 1'b1, 1'b0, ov);
            4: return mk(3'd4, 2'd1, 3'd4, {3'b000, en, 1'b0}, 1'b0, 1'b1, 1'b0, ov);
            5: return mk(3'd5, 2'd2, 3'd5, {4'b0000, en}, 1'b0, 1'b1, 1'b0, ov);
            6: return mk(3'd0, 2'd0, 3'd0, 5'b0, 1'b1, 1'b1, 1'b1, ov);
            default: return mk(3'd0, 2'd0, 3'd0, 5'b0, 1'b0, 1'b0, 1'b0, ov);
        endcase
    endfunction

    typedef struct {
        logic        start;
        logic        clr;
        logic [16:0] exp;
    } vec_t;
    vec_t tbl[15];

    task automatic setrow(input int i, input logic st, input logic cl, input int k, input logic ov);
        tbl[i].start = st;
        tbl[i].clr   = cl;
        tbl[i].exp   = expv(k, 1'b1, ov);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; ovr_clr = 1'b0; bypass = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        logic seen;
        uk = '0;
        // row = cycle: inputs driven in that cycle, outputs expected in that cycle
        setrow(0,  1, 0, 0, 0);
        setrow(1,  0, 0, 1, 0);
        setrow(2,  0, 0, 2, 0);
        setrow(3,  1, 0, 3, 0);
        setrow(4,  0, 0, 4, 1);
        setrow(5,  0, 0, 5, 1);
        setrow(6,  1, 0, 6, 1);
        setrow(7,  1, 0, 0, 1);
        setrow(8,  0, 0, 1, 1);
        setrow(9,  0, 0, 2, 1);
        setrow(10, 0, 1, 3, 1);
        setrow(11, 0, 0, 4, 0);
        setrow(12, 0, 0, 5, 0);
        setrow(13, 0, 0, 6, 0);
        setrow(14, 0, 0, 0, 0);

        reset = 1'b1; start = 1'b0; ovr_clr = 1'b0; bypass = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_u1", 32'(obs1), 32'h0);
        chk("reset_u3", 32'(obs3), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk($sformatf("tbl_row%0d", i), 32'(obs1), 32'(tbl[i].exp));
            start   = tbl[i].start;
            ovr_clr = tbl[i].clr;
        end
        @(negedge clk);
        start = 1'b0; ovr_clr = 1'b0;

        // MAC_LAT=3: each step held three cycles, enable in the third
        do_reset();
        @(negedge clk);
        start = 1'b1;
        busy_cnt = 0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (bz_3) busy_cnt++;
            if (c <= 15)
                chk($sformatf("ml3_c%0d", c), 32'(obs3), 32'(expv((c - 1) / 3 + 1, ((c - 1) % 3) == 2, 1'b0)));
            else if (c == 16)
                chk("ml3_shift", 32'(obs3), 32'(expv(6, 1'b1, 1'b0)));
        end
        chk("ml3_busy_cycles", 32'(busy_cnt), 32'd16);

        // reset in cycle 3 aborts the sample
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_c4", 32'(obs1), 32'h0);
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen = seen | yk_1 | sh_1 | dn_1;
        end
        chk("abort_no_tail", 32'(seen), 32'h0);

        // overrun set beats ovr_clr in the same cycle
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; ovr_clr = 1'b1;
        @(negedge clk);
        start = 1'b0; ovr_clr = 1'b0;
        chk("set_wins_c3", 32'(obs1), 32'(expv(3, 1'b1, 1'b1)));
        repeat (5) @(negedge clk);

        // impulse through the datapath from zero state
        do_reset();
        uk = 16'sd16384;
        @(negedge clk);
        start = 1'b1;
        seen = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 6) seen = dn_1;
        end
        chk("imp_done_c6", 32'(seen), 32'h1);
        chk("imp_yk", 32'(yk), 32'(16'sd16351));
        chk("imp_fk", 32'(fk), 32'(16'sd16384));
        chk("imp_fk1", 32'(fk1), 32'(16'sd16384));
        chk("imp_fk2", 32'(fk2), 32'h0);

`ifdef BIQUAD_BYPASS_EN
        uk = 16'sd1234;
        @(negedge clk);
        start = 1'b1; bypass = 1'b1;
        @(negedge clk);
        start = 1'b0; bypass = 1'b0;
        chk("byp_c1", 32'(obs1), 32'(mk(3'd0, 2'd0, 3'd1, 5'b00001, 1'b0, 1'b1, 1'b0, 1'b0)));
        @(negedge clk);
        chk("byp_c2", 32'(obs1), 32'(mk(3'd0, 2'd0, 3'd0, 5'b00000, 1'b0, 1'b1, 1'b1, 1'b0)));
        @(negedge clk);
        chk("byp_yk", 32'(yk), 32'(16'sd1234));
        chk("byp_fk1", 32'(fk1), 32'(16'sd16384));
        chk("byp_fk2", 32'(fk2), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/biquad_sequencer.md
Name: biquad_sequencer

Overview:
- Control FSM for the shared biquad multiply-accumulate datapath: coefficient mux, sample mux and addend mux feeding one multiplier and adder.
- On each sample strobe it runs the 5-step direct-form-II computation (f_k, then y_k) and updates the delay line.
- Outputs are the three mux selects plus register load enables.
- Sits between the sample-rate timer/ADC interface and the filter datapath.

Parameters:
- MAC_LAT, 1, cycles each step's selects are held before its load enable fires (multiplier pipeline depth); legal range 1..8.
- CNT_W, 3, width of the step-hold counter; must satisfy 2^CNT_W >= MAC_LAT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  one-cycle sample strobe (U_k valid)
- ovr_clr  input  1  clears overrun
- controlS  output  3  coefficient select: 000 cero, 001 a1, 010 a2, 011 b0, 100 b1, 101 b2
- controlC  output  2  sample select: 00 cero, 01 f_{k-1}, 10 f_{k-2}, 11 f_k
- controlZ  output  3  addend select: 000 cero, 001 U_k, 010 y_k, 011 acum1, 100 acum2, 101 acum3
- en_acum1 / en_acum2 / en_acum3 / en_fk / en_yk  output  1 each  datapath register load enables
- en_shift  output  1  delay-line shift: f_{k-2} <= f_{k-1}, f_{k-1} <= f_k
- busy  output  1  high while not IDLE
- done  output  1  one-cycle pulse, y_k valid on the next cycle
- overrun  output  1  sticky: start arrived while busy

Behaviour:
- Reset: state IDLE, hold counter 0. All selects 000/00/000, all enables, busy, done and overrun are 0. Reset mid-sequence aborts on the next edge with no further enables.
- States: IDLE, ST1..ST5, SHIFT.
- Step table (S, C, Z, enable):
  - ST1: 001, 01, 001, en_acum1 (a1*f_{k-1} + U_k)
  - ST2: 010, 10, 011, en_fk (f_k)
  - ST3: 011, 11, 000, en_acum2
  - ST4: 100, 01, 100, en_acum3
  - ST5: 101, 10, 101, en_yk
- Timing:
  - Each ST state holds its selects for MAC_LAT cycles. Its enable is high only in the last of those cycles (counter == MAC_LAT-1), then the FSM advances.
  - SHIFT lasts 1 cycle: en_shift = done = 1, selects 0, then IDLE.
  - IDLE -> ST1 when start=1.
  - Latency: start sampled at edge 0, so done is high in cycle 5*MAC_LAT+1. busy is high exactly 5*MAC_LAT+1 cycles.
- Outputs are registered-state decodes (Moore). Selects are 0 in IDLE and SHIFT.
- Boundary cases:
  - start while busy (including the SHIFT cycle) is ignored and sets overrun; the sequence in progress is not disturbed.
  - start in the first IDLE cycle after SHIFT is accepted.
  - ovr_clr and a new overrun event in the same cycle: overrun stays 1, because set wins.
  - Select codes 110/111 are never driven.

Optional Feature:
- Macro BIQUAD_BYPASS_EN adds an input port bypass (1 bit), sampled together with start.
- With the macro defined, start with bypass=1 enters state BYP for MAC_LAT cycles with S=000, C=00, Z=001 (y_k = U_k). en_yk fires in the last BYP cycle. SHIFT follows with en_shift=0 and done=1, so the delay line is frozen. Latency is MAC_LAT+1.
- Without the macro: no port, no BYP state, and behaviour is exactly the 5-step flow.

Decomposition:
- Shared constants header: N and F word widths plus named select codes (SEL_CERO, SEL_A1..SEL_B2, SEL_FK/FK1/FK2, SEL_UK/YK/ACUM1..3) and the state encoding. The datapath mux and this FSM use the same header.
- One natural sub-module, step_timer: CNT_W-bit hold counter with clear/terminal-count output. Everything else stays flat.

Test Plan:
- MAC_LAT=1, start pulse at cycle 0 -> cycles 1..5 show (S,C,Z) = 001/01/001, 010/10/011, 011/11/000, 100/01/100, 101/10/101 with en_acum1, en_fk, en_acum2, en_acum3, en_yk one-hot in that order. Cycle 6 has en_shift=done=1. busy is high in cycles 1..6 only.
- MAC_LAT=3 -> busy high for 16 cycles, en_acum1 only in cycle 3, done in cycle 16, and each select pattern stable for 3 cycles.
- Second start at cycle 3 and again at cycle 6 (MAC_LAT=1) -> both ignored, overrun=1 from cycle 4, and the sequence is unchanged. ovr_clr at cycle 10 -> overrun=0 at cycle 11. Start at cycle 7 is accepted.
- reset asserted in cycle 3 of a sequence -> cycle 4 has all outputs 0 and IDLE; no en_yk/en_shift/done is ever emitted for that sample.
- With the datapath attached (F=14, zero state), U_k=16384 impulse -> y_k = 16351 (b0), f_k = 16384. After done, f_{k-1} = 16384 and f_{k-2} = 0.
- BIQUAD_BYPASS_EN with bypass=1 and U_k=1234, MAC_LAT=1 -> en_yk in cycle 1 with Z=001, S=C=0. done in cycle 2 with en_shift=0. y_k = 1234 and the delay line is unchanged.
